// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - port bundle for the multi-port register file with busy scoreboard
interface regfile_mp_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
);
    logic [NUM_WR-1:0]            we_i;
    logic [NUM_WR*ADDR_WIDTH-1:0] rw_i;
    logic [NUM_WR*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_RD*ADDR_WIDTH-1:0] ra_i;
    logic [NUM_RD*DATA_WIDTH-1:0] rdata_o;
    logic [NUM_RD-1:0]            rbusy_o;
    logic                         rsv_we_i;
    logic [ADDR_WIDTH-1:0]        rsv_addr_i;
    logic                         flush_i;
    logic [ADDR_WIDTH:0]          busy_cnt_o;

    modport master (
        output we_i, rw_i, wdata_i, ra_i, rsv_we_i, rsv_addr_i, flush_i,
        input  rdata_o, rbusy_o, busy_cnt_o
    );

    modport slave (
        input  we_i, rw_i, wdata_i, ra_i, rsv_we_i, rsv_addr_i, flush_i,
        output rdata_o, rbusy_o, busy_cnt_o
    );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with per-register busy scoreboard; optional REGFILE_BYPASS_EN forwarding
module regfile_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
) (
    input logic         clk_i,
    input logic         rstn_i,
    regfile_mp_if.slave bus
);
    localparam int NREG = 2 ** ADDR_WIDTH;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]       busy_q;
    logic [NREG-1:0]       busy_d;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic [ADDR_WIDTH:0]   cnt_d;

    logic [ADDR_WIDTH-1:0] wa [NUM_WR];
    logic [DATA_WIDTH-1:0] wd [NUM_WR];
    logic [NUM_WR-1:0]     wv;
    logic [ADDR_WIDTH-1:0] ra [NUM_RD];
    logic [DATA_WIDTH-1:0] rd [NUM_RD];
    logic [NUM_RD-1:0]     rb;
    logic                  rsv_ok;

    // Unpack write ports; a write is only effective for a nonzero address
    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            wa[k] = bus.rw_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            wd[k] = bus.wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            wv[k] = bus.we_i[k] && (wa[k] != '0);
        end
    end

    assign rsv_ok = bus.rsv_we_i && (bus.rsv_addr_i != '0);

    // Next busy vector: writes clear, reserve sets (wins over write), flush clears everything
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wv[k]) busy_d[wa[k]] = 1'b0;
        end
        if (rsv_ok) busy_d[bus.rsv_addr_i] = 1'b1;
        if (bus.flush_i) busy_d = '0;
        busy_d[0] = 1'b0;
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
        end
    end

    // Register array; later write ports overwrite earlier ones on address collision
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wv[k]) regs[wa[k]] <= wd[k];
            end
        end
    end

    // Busy bits and their registered popcount
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Combinational read ports, with optional forwarding of the winning same-cycle write
    always_comb begin
        for (int j = 0; j < NUM_RD; j++) begin
            ra[j] = bus.ra_i[j*ADDR_WIDTH +: ADDR_WIDTH];
            rd[j] = regs[ra[j]];
            rb[j] = busy_q[ra[j]];
            if (BYPASS) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wv[k] && (wa[k] == ra[j])) begin
                        rd[j] = wd[k];
                        rb[j] = rsv_ok && (bus.rsv_addr_i == ra[j]);
                    end
                end
            end
            if (!rstn_i || (ra[j] == '0)) begin
                rd[j] = '0;
                rb[j] = 1'b0;
            end
        end
    end

    // Pack read results onto the bus
    always_comb begin
        bus.rdata_o = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            bus.rdata_o[j*DATA_WIDTH +: DATA_WIDTH] = rd[j];
        end
    end

    assign bus.rbusy_o    = rb;
    assign bus.busy_cnt_o = cnt_q;
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Param ADDR_WIDTH, default 5, register address width; 2**ADDR_WIDTH registers, x0 included.
REQ-002 Param DATA_WIDTH, default 32, register data width.
REQ-003 Param NUM_RD, default 2, read port count, legal 1..4.
REQ-004 Param NUM_WR, default 1, write port count, legal 1..2.
REQ-005 clk_i  in  1  single clock, all state updates on rising edge.
REQ-006 rstn_i  in  1  reset, asynchronous, active-low.
REQ-007 we_i  in  NUM_WR  per-port write enable.
REQ-008 rw_i  in  NUM_WR*ADDR_WIDTH  write addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 wdata_i  in  NUM_WR*DATA_WIDTH  write data, packed as rw_i.
REQ-010 ra_i  in  NUM_RD*ADDR_WIDTH  read addresses, packed likewise.
REQ-011 rdata_o  out  NUM_RD*DATA_WIDTH  read data, combinational.
REQ-012 rbusy_o  out  NUM_RD  per-read-port operand-not-ready flag, combinational.
REQ-013 rsv_we_i  in  1  reserve request: mark destination busy (instruction issued).
REQ-014 rsv_addr_i  in  ADDR_WIDTH  register to reserve.
REQ-015 flush_i  in  1  synchronous clear of all busy bits.
REQ-016 busy_cnt_o  out  ADDR_WIDTH+1  registered count of busy registers.

Function
REQ-017 Register 0 SHALL read 0 and report busy 0 on every port; writes and reserves to address 0 SHALL be ignored.
REQ-018 Write port k with we_i[k]=1 and nonzero address SHALL update that register on the next rising edge.
REQ-019 Two write ports to the same address in one cycle: higher-index port SHALL win.
REQ-020 Each nonzero register SHALL carry one busy bit; rsv_we_i SHALL set bit rsv_addr_i at the next edge.
REQ-021 A write to register r SHALL clear busy bit r at the next edge.
REQ-022 Reserve and write to the same r in one cycle: data SHALL be written and busy SHALL remain/become 1 (reserve wins).
REQ-023 flush_i SHALL clear all busy bits at the next edge, overriding same-cycle reserve; same-cycle writes SHALL still commit data.
REQ-024 busy_cnt_o SHALL equal the popcount of busy bits after each edge, range 0..2**ADDR_WIDTH-1, no wrap.
REQ-025 rbusy_o[j] SHALL be the stored busy bit of ra_i[j], subject to REQ-017 and REQ-031.
REQ-026 Read latency SHALL be zero cycles (combinational from ra_i and array state).

Reset
REQ-027 rstn_i low SHALL asynchronously clear all registers, all busy bits and busy_cnt_o to 0.
REQ-028 During reset, rdata_o and rbusy_o SHALL be 0 on all ports; writes/reserves SHALL be ignored.
REQ-029 Reset deassertion SHALL require no warm-up; first edge after release SHALL accept writes.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN SHALL select same-cycle write-to-read forwarding.
REQ-031 Defined: a read of r while port k writes r SHALL return wdata_i of the winning port (REQ-019) and rbusy_o 0 unless rsv_we_i also targets r; undefined: read SHALL return stored value and stored busy bit, new data visible the following cycle.

Verification
REQ-032 Reset mid-operation: write x5=0xDEADBEEF, reserve x6, assert rstn_i=0 between edges -> rdata x5=0, rbusy x6=0, busy_cnt_o=0 immediately.
REQ-033 x0 protection: we=1 rw=0 wdata=0xFFFFFFFF, rsv x0 -> ra=0 reads 0, rbusy 0, busy_cnt_o 0.
REQ-034 Scoreboard: rsv x3, next cycle read x3 -> rbusy 1, busy_cnt_o 1; write x3=0x1234 -> next cycle rbusy 0, rdata 0x1234, count 0.
REQ-035 Collision (NUM_WR=2): both ports write x7, port0=0xAAAA port1=0x5555 with same-cycle rsv x7 -> x7=0x5555, rbusy 1.
REQ-036 Bypass: write x9=0xCAFE with ra=9 same cycle -> with REGFILE_BYPASS_EN rdata 0xCAFE; without, old value, 0xCAFE next cycle.
REQ-037 Flush: reserve x1..x4 over 4 cycles, flush_i with rsv x5 -> busy_cnt_o 0, all rbusy 0.
